// File: rtl/twisted_ring_ctr.sv
// twisted_ring_ctr
//   Parametrised shift-register phase counter used as a glitch-free phase and
//   sequence generator for clock-enable and strobe distribution.
//   MODE 0 = Johnson (2*WIDTH phases), MODE 1 = one-hot ring (WIDTH phases).
//   The counter alongside the shift register tracks the binary phase index, so
//   downstream logic can decode the phase without looking at the raw pattern.
//
//   Optional feature macro: TRC_SELF_CORRECT_EN
//     When defined, a registered checker flags any ctr value that differs from
//     the encoding of the tracked phase. The following cycle forces the
//     counter back to phase 0. When undefined, illegal is tied low and the
//     checker is not built.
//
// Ports
//   clk         in   1      clock, rising edge
//   rst         in   1      synchronous reset, active-high
//   en          in   1      advance one phase this cycle
//   dir         in   1      0 = up, 1 = down (used only when en = 1)
//   load        in   1      load load_phase this cycle (beats en)
//   load_phase  in   PW     phase index to load, legal range 0..NST-1
//   ctr         out  WIDTH  shift-register state
//   phase       out  PW     binary phase index of ctr
//   wrap        out  1      1-cycle pulse after a step across the NST-1 / 0 boundary
//   load_err    out  1      1-cycle pulse after a load with load_phase >= NST
//   illegal     out  1      ctr is not a valid encoding (self-correct build only)

module twisted_ring_ctr #(
    parameter int  WIDTH = 4,
    parameter int  MODE  = 0,
    localparam int NST   = (MODE == 1) ? WIDTH : 2 * WIDTH,
    localparam int PW    = $clog2(NST)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [PW-1:0]    load_phase,
    output logic [WIDTH-1:0] ctr,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             load_err,
    output logic             illegal
);

    localparam logic [PW-1:0]    PH_LAST  = PW'(NST - 1);
    localparam logic [PW:0]      NST_EXT  = (PW + 1)'(NST);
    localparam logic [WIDTH-1:0] CTR_ZERO = (MODE == 1) ? WIDTH'(1) : WIDTH'(0);

    // Pattern for a phase index. Johnson phase p fills ones in from the MSB
    // for the first WIDTH steps, then fills zeros in from the MSB.
    function automatic logic [WIDTH-1:0] encode(input logic [PW-1:0] p);
        logic [WIDTH-1:0] v;
        int               pi;
        v  = '0;
        pi = int'(p);
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE == 1)
                v[i] = (pi == i);
            else if (pi <= WIDTH)
                v[i] = (i >= WIDTH - pi);
            else
                v[i] = (i < 2 * WIDTH - pi);
        end
        return v;
    endfunction

    logic [WIDTH-1:0] shift_up;
    logic [WIDTH-1:0] shift_dn;
    logic [WIDTH-1:0] ctr_nxt;
    logic [PW-1:0]    phase_nxt;
    logic             wrap_nxt;
    logic             load_err_nxt;
    logic             load_ok;
    logic             fix;

    always_comb begin
        if (MODE == 1) begin
            shift_up = {ctr[WIDTH-2:0], ctr[WIDTH-1]};
            shift_dn = {ctr[0], ctr[WIDTH-1:1]};
        end else begin
            shift_up = {~ctr[0], ctr[WIDTH-1:1]};
            shift_dn = {ctr[WIDTH-2:0], ~ctr[WIDTH-1]};
        end
    end

    // Only reachable when NST is not a power of two; otherwise folds to 1.
    assign load_ok = ({1'b0, load_phase} < NST_EXT);

`ifdef TRC_SELF_CORRECT_EN
    logic illegal_q;
    logic illegal_nxt;

    assign fix     = illegal_q;
    assign illegal = illegal_q;

    // Held low during the repair cycle so the flag is a single pulse even
    // though ctr still shows the bad pattern on that cycle.
    always_comb begin
        illegal_nxt = 1'b0;
        if (!fix)
            illegal_nxt = (ctr != encode(phase));
    end

    always_ff @(posedge clk) begin
        if (rst)
            illegal_q <= 1'b0;
        else
            illegal_q <= illegal_nxt;
    end
`else
    assign fix     = 1'b0;
    assign illegal = 1'b0;
`endif

    always_comb begin
        ctr_nxt      = ctr;
        phase_nxt    = phase;
        wrap_nxt     = 1'b0;
        load_err_nxt = 1'b0;
        if (fix) begin
            ctr_nxt   = CTR_ZERO;
            phase_nxt = '0;
        end else if (load) begin
            if (load_ok) begin
                ctr_nxt   = encode(load_phase);
                phase_nxt = load_phase;
            end else begin
                load_err_nxt = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                ctr_nxt = shift_up;
                if (phase == PH_LAST) begin
                    phase_nxt = '0;
                    wrap_nxt  = 1'b1;
                end else begin
                    phase_nxt = phase + PW'(1);
                end
            end else begin
                ctr_nxt = shift_dn;
                if (phase == '0) begin
                    phase_nxt = PH_LAST;
                    wrap_nxt  = 1'b1;
                end else begin
                    phase_nxt = phase - PW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctr      <= CTR_ZERO;
            phase    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            ctr      <= ctr_nxt;
            phase    <= phase_nxt;
            wrap     <= wrap_nxt;
            load_err <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_twisted_ring_ctr.sv
module tb_twisted_ring_ctr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: Johnson W=4 (NST 8), B: ring W=4 (NST 4), C: Johnson W=3 (NST 6)
    logic       a_rst = 1'b1, a_en = 1'b0, a_dir = 1'b0, a_load = 1'b0;
    logic [2:0] a_lp = '0;
    logic [3:0] a_ctr;
    logic [2:0] a_phase;
    logic       a_wrap, a_err, a_illegal;

    logic       b_rst = 1'b1, b_en = 1'b0, b_dir = 1'b0, b_load = 1'b0;
    logic [1:0] b_lp = '0;
    logic [3:0] b_ctr;
    logic [1:0] b_phase;
    logic       b_wrap, b_err, b_illegal;

    logic       c_rst = 1'b1, c_en = 1'b0, c_dir = 1'b0, c_load = 1'b0;
    logic [2:0] c_lp = '0;
    logic [2:0] c_ctr;
    logic [2:0] c_phase;
    logic       c_wrap, c_err, c_illegal;

    twisted_ring_ctr #(.WIDTH(4), .MODE(0)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .dir(a_dir), .load(a_load),
        .load_phase(a_lp), .ctr(a_ctr), .phase(a_phase), .wrap(a_wrap),
        .load_err(a_err), .illegal(a_illegal));

    twisted_ring_ctr #(.WIDTH(4), .MODE(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .dir(b_dir), .load(b_load),
        .load_phase(b_lp), .ctr(b_ctr), .phase(b_phase), .wrap(b_wrap),
        .load_err(b_err), .illegal(b_illegal));

    twisted_ring_ctr #(.WIDTH(3), .MODE(0)) dut_c (
        .clk(clk), .rst(c_rst), .en(c_en), .dir(c_dir), .load(c_load),
        .load_phase(c_lp), .ctr(c_ctr), .phase(c_phase), .wrap(c_wrap),
        .load_err(c_err), .illegal(c_illegal));

    typedef struct {
        int         tag;
        int         id;
        logic [3:0] ctr;
        logic [2:0] ph;
        logic       wrap;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   tag_n    = 0;

    function automatic void chk(input int tag, input string what,
                                input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL step%0d %s observed=%b expected=%b", tag, what, obs, exp);
        end
    endfunction

    task automatic compare();
        exp_t       x;
        logic [3:0] oc;
        logic [3:0] op;
        logic       ow, oe, oi;
        x = sb.pop_front();
        case (x.id)
            0: begin oc = a_ctr;         op = {1'b0, a_phase};       ow = a_wrap; oe = a_err; oi = a_illegal; end
            1: begin oc = b_ctr;         op = {2'b00, b_phase};      ow = b_wrap; oe = b_err; oi = b_illegal; end
            default: begin oc = {1'b0, c_ctr}; op = {1'b0, c_phase}; ow = c_wrap; oe = c_err; oi = c_illegal; end
        endcase
        chk(x.tag, "ctr",      oc,            x.ctr);
        chk(x.tag, "phase",    op,            {1'b0, x.ph});
        chk(x.tag, "wrap",     {3'b000, ow},  {3'b000, x.wrap});
        chk(x.tag, "load_err", {3'b000, oe},  {3'b000, x.err});
        chk(x.tag, "illegal",  {3'b000, oi},  4'b0000);
    endtask

    task automatic step(input int id, input logic r, input logic e, input logic d,
                        input logic l, input logic [2:0] lp, input logic [3:0] ec,
                        input logic [2:0] ep, input logic ew, input logic ee);
        exp_t x;
        case (id)
            0: begin a_rst = r; a_en = e; a_dir = d; a_load = l; a_lp = lp; end
            1: begin b_rst = r; b_en = e; b_dir = d; b_load = l; b_lp = lp[1:0]; end
            default: begin c_rst = r; c_en = e; c_dir = d; c_load = l; c_lp = lp; end
        endcase
        x.tag  = tag_n;
        x.id   = id;
        x.ctr  = ec;
        x.ph   = ep;
        x.wrap = ew;
        x.err  = ee;
        tag_n++;
        sb.push_back(x);
        @(posedge clk);
        #1;
        compare();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        b_rst = 1'b0;
        c_rst = 1'b0;

        // ---- A: Johnson W=4 ----
        step(0, 1,0,0,0, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(0, 1,1,0,1, 3'd3, 4'b0000, 3'd0, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b1000, 3'd1, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b1100, 3'd2, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b1110, 3'd3, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b1111, 3'd4, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0111, 3'd5, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0011, 3'd6, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0001, 3'd7, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0000, 3'd0, 1, 0);
        step(0, 0,1,0,0, 3'd0, 4'b1000, 3'd1, 0, 0);
        step(0, 0,1,1,0, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(0, 0,1,1,0, 3'd0, 4'b0001, 3'd7, 1, 0);
        step(0, 0,1,1,0, 3'd0, 4'b0011, 3'd6, 0, 0);
        step(0, 0,0,1,0, 3'd0, 4'b0011, 3'd6, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0001, 3'd7, 0, 0);
        step(0, 0,1,1,0, 3'd0, 4'b0011, 3'd6, 0, 0);
        step(0, 0,1,0,1, 3'd5, 4'b0111, 3'd5, 0, 0);
        step(0, 0,1,0,1, 3'd3, 4'b1110, 3'd3, 0, 0);
        step(0, 0,1,1,1, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(0, 0,0,0,1, 3'd7, 4'b0001, 3'd7, 0, 0);
        step(0, 0,1,0,0, 3'd0, 4'b0000, 3'd0, 1, 0);
        step(0, 0,0,0,0, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(0, 0,0,0,1, 3'd6, 4'b0011, 3'd6, 0, 0);
        step(0, 1,1,0,1, 3'd2, 4'b0000, 3'd0, 0, 0);
        step(0, 0,0,0,0, 3'd0, 4'b0000, 3'd0, 0, 0);

        // ---- B: ring W=4 ----
        step(1, 1,0,0,0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step(1, 0,1,0,0, 3'd0, 4'b0010, 3'd1, 0, 0);
        step(1, 0,1,0,0, 3'd0, 4'b0100, 3'd2, 0, 0);
        step(1, 0,1,0,0, 3'd0, 4'b1000, 3'd3, 0, 0);
        step(1, 0,1,0,0, 3'd0, 4'b0001, 3'd0, 1, 0);
        step(1, 0,1,0,0, 3'd0, 4'b0010, 3'd1, 0, 0);
        step(1, 0,1,1,0, 3'd0, 4'b0001, 3'd0, 0, 0);
        step(1, 0,1,1,0, 3'd0, 4'b1000, 3'd3, 1, 0);
        step(1, 0,1,1,1, 3'd2, 4'b0100, 3'd2, 0, 0);
        step(1, 0,0,0,0, 3'd0, 4'b0100, 3'd2, 0, 0);

        // ---- C: Johnson W=3, NST 6, out-of-range loads reachable ----
        step(2, 1,0,0,0, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(2, 0,1,0,1, 3'd6, 4'b0000, 3'd0, 0, 1);
        step(2, 0,0,0,0, 3'd0, 4'b0000, 3'd0, 0, 0);
        step(2, 0,0,0,1, 3'd4, 4'b0011, 3'd4, 0, 0);
        step(2, 0,1,0,1, 3'd7, 4'b0011, 3'd4, 0, 1);
        step(2, 0,1,0,0, 3'd0, 4'b0001, 3'd5, 0, 0);
        step(2, 0,1,0,0, 3'd0, 4'b0000, 3'd0, 1, 0);
        step(2, 0,1,1,0, 3'd0, 4'b0001, 3'd5, 1, 0);
        step(2, 0,1,0,1, 3'd3, 4'b0111, 3'd3, 0, 0);
        step(2, 0,0,0,0, 3'd0, 4'b0111, 3'd3, 0, 0);

`ifdef TRC_SELF_CORRECT_EN
        @(negedge clk);
        force dut_a.ctr = 4'b0101;
        @(posedge clk);
        #1;
        release dut_a.ctr;
        chk(900, "sc_illegal_set", {3'b000, a_illegal}, 4'b0001);
        @(posedge clk);
        #1;
        chk(901, "sc_ctr",         a_ctr,               4'b0000);
        chk(902, "sc_phase",       {1'b0, a_phase},     4'b0000);
        chk(903, "sc_illegal_clr", {3'b000, a_illegal}, 4'b0000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
